// File: rtl/gfifo_mchan_stream_if.sv
// gfifo_mchan_stream_if: multi-channel producer side plus merged output stream.
// The slave modport is the merger's view; the master modport is the environment's view.
interface gfifo_mchan_stream_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 512,
    parameter int ID_W   = 22,
    parameter int LEN_W  = 4
);
    localparam int CH_W = $clog2(NUM_CH);
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH*ID_W-1:0]   in_id;
    logic [NUM_CH-1:0]        in_last;
    logic [DATA_W-1:0]        out_data;
    logic [ID_W-1:0]          out_id;
    logic                     out_data_en;
    logic [LEN_W-1:0]         out_data_len;
    logic                     out_last;
    logic [CH_W-1:0]          out_ch;
    logic                     out_ready;
    logic                     err_overlen;
    modport slave (
        input  in_valid, in_data, in_id, in_last, out_ready,
        output in_ready, out_data, out_id, out_data_en, out_data_len, out_last, out_ch, err_overlen
    );
    modport master (
        output in_valid, in_data, in_id, in_last, out_ready,
        input  in_ready, out_data, out_id, out_data_en, out_data_len, out_last, out_ch, err_overlen
    );
endinterface

// File: rtl/gfifo_mchan_stream.sv
// gfifo_mchan_stream: per-channel beat buffers merged onto one output stream
// by a round-robin arbiter that grants whole messages.
module gfifo_mchan_stream #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 512,
    parameter int ID_W   = 22,
    parameter int LEN_W  = 4,
    parameter int DEPTH  = 8
) (
    input logic clk,
    input logic rst_n,
    gfifo_mchan_stream_if.slave bus
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    typedef enum logic {IDLE, BURST} state_t;
    state_t            state_q;
    logic [PTR_W:0]    wr_q [NUM_CH];
    logic [PTR_W:0]    rd_q [NUM_CH];
    logic [DATA_W-1:0] data_mem [NUM_CH][DEPTH];
    logic [ID_W-1:0]   id_mem [NUM_CH][DEPTH];
    logic [DEPTH-1:0]  last_mem [NUM_CH];
    logic [NUM_CH-1:0] empty, full, push, pop;
    logic [CH_W-1:0]   rr_q, grant_q, idx, sel, pop_ch, rr_d;
    logic [LEN_W-1:0]  cnt_q, len_d;
    logic [PTR_W-1:0]  head_idx;
    logic              slot_free, do_pop, head_last, last_d;
    logic [DATA_W-1:0] out_data_q;
    logic [ID_W-1:0]   out_id_q;
    logic [LEN_W-1:0]  out_len_q;
    logic [CH_W-1:0]   out_ch_q;
    logic              out_en_q, out_last_q, err_q;
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            empty[c] = wr_q[c] == rd_q[c];
            full[c]  = wr_q[c] == {~rd_q[c][PTR_W], rd_q[c][PTR_W-1:0]};
        end
    end
    assign bus.in_ready = rst_n ? ~full : '0;
    assign push = bus.in_valid & bus.in_ready;
    // Scan downward so the non-empty channel closest to the RR pointer wins.
    always_comb begin
        sel = '0;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = CH_W'((int'(rr_q) + i) % NUM_CH);
            if (!empty[idx]) sel = idx;
        end
    end
    assign pop_ch    = state_q == IDLE ? sel : grant_q;
    assign slot_free = !out_en_q || bus.out_ready;
    assign do_pop    = slot_free && !empty[pop_ch];
    assign pop       = do_pop ? NUM_CH'(1) << pop_ch : '0;
    assign head_idx  = rd_q[pop_ch][PTR_W-1:0];
    assign head_last = last_mem[pop_ch][head_idx];
    assign len_d     = state_q == IDLE ? '0 : cnt_q;
    assign last_d    = head_last || len_d == LEN_MAX;
    assign rr_d      = sel == CH_W'(NUM_CH - 1) ? '0 : sel + 1'b1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_q[c] <= '0;
                rd_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (push[c]) wr_q[c] <= wr_q[c] + 1'b1;
                if (pop[c]) rd_q[c] <= rd_q[c] + 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++)
            if (push[c]) begin
                data_mem[c][wr_q[c][PTR_W-1:0]] <= bus.in_data[c*DATA_W +: DATA_W];
                id_mem[c][wr_q[c][PTR_W-1:0]]   <= bus.in_id[c*ID_W +: ID_W];
                last_mem[c][wr_q[c][PTR_W-1:0]] <= bus.in_last[c];
            end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            grant_q    <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
            out_id_q   <= '0;
            out_len_q  <= '0;
            out_ch_q   <= '0;
            out_en_q   <= 1'b0;
            out_last_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (slot_free) out_en_q <= do_pop;
            if (do_pop) begin
                out_data_q <= data_mem[pop_ch][head_idx];
                out_id_q   <= id_mem[pop_ch][head_idx];
                out_len_q  <= len_d;
                out_last_q <= last_d;
                out_ch_q   <= pop_ch;
                grant_q    <= pop_ch;
                cnt_q      <= len_d + 1'b1;
                state_q    <= last_d ? IDLE : BURST;
                if (state_q == IDLE) rr_q <= rr_d;
                // An overlong message is cut here; its remaining beats start a new one.
                if (!head_last && len_d == LEN_MAX) err_q <= 1'b1;
            end
        end
    end
    assign bus.out_data     = out_data_q;
    assign bus.out_id       = out_id_q;
    assign bus.out_data_en  = out_en_q;
    assign bus.out_data_len = out_len_q;
    assign bus.out_last     = out_last_q;
    assign bus.out_ch       = out_ch_q;
    assign bus.err_overlen  = err_q;
endmodule

// File: tb/tb_gfifo_mchan_stream.sv
// tb_gfifo_mchan_stream: directed vectors for the multi-channel stream merger.
module tb_gfifo_mchan_stream;
    localparam int NC = 4, DW = 512, IW = 22, LW = 4, DP = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    gfifo_mchan_stream_if #(.NUM_CH(NC), .DATA_W(DW), .ID_W(IW), .LEN_W(LW)) bus ();
    gfifo_mchan_stream #(.NUM_CH(NC), .DATA_W(DW), .ID_W(IW), .LEN_W(LW), .DEPTH(DP)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    typedef struct packed {
        logic [1:0]  ch;
        logic [3:0]  len;
        logic        last;
        logic [15:0] data;
        logic [21:0] id;
    } beat_t;
    beat_t q[$];
    int    cyc_q[$];
    int    cyc = 0;
    int    vectors = 0, miscompares = 0;
    always @(posedge clk) cyc <= cyc + 1;
    // A beat seen valid and ready at the falling edge is accepted at the next rising edge.
    always @(negedge clk)
        if (bus.out_data_en && bus.out_ready) begin
            q.push_back(beat_t'{bus.out_ch, bus.out_data_len, bus.out_last, bus.out_data[15:0], bus.out_id});
            cyc_q.push_back(cyc);
        end
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic drive(input int c, input logic v, input int d, input int id, input logic l);
        bus.in_valid[c]          = v;
        bus.in_data[c*DW +: DW]  = DW'(d);
        bus.in_id[c*IW +: IW]    = IW'(id);
        bus.in_last[c]           = l;
    endtask
    task automatic push(input int c, input int d, input int id, input logic l);
        drive(c, 1'b1, d, id, l);
        for (int n = 0; n < 50 && !bus.in_ready[c]; n++) tick(1);
        chk("push ready", 64'(bus.in_ready[c]), 64'(1));
        tick(1);
        drive(c, 1'b0, 0, 0, 1'b0);
    endtask
    task automatic expect_beat(input string tag, input int ch, input int len, input int last,
                               input int data, input int id, output int c);
        beat_t b, e;
        e = beat_t'{2'(ch), 4'(len), 1'(last), 16'(data), 22'(id)};
        b = '0;
        c = -1;
        if (q.size() > 0) begin
            b = q.pop_front();
            c = cyc_q.pop_front();
        end
        chk(tag, 64'(b), 64'(e));
    endtask
    task automatic do_reset();
        bus.in_valid = '0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask
    initial begin
        int c0, ci, sent;
        logic acc;
        bus.in_valid = '0; bus.in_last = '0; bus.in_data = '0; bus.in_id = '0; bus.out_ready = 1'b1;
        #2;
        chk("rst en", 64'(bus.out_data_en), 64'(0));
        chk("rst in_ready", 64'(bus.in_ready), 64'(0));
        chk("rst err", 64'(bus.err_overlen), 64'(0));
        tick(2);
        rst_n = 1'b1;
        #1;
        chk("rel in_ready", 64'(bus.in_ready), 64'hF);
        // ch0 three-beat message and first-beat latency
        drive(0, 1'b1, 'hA0, 'h15, 1'b0); tick(1);
        chk("t1 lat edgeT", 64'(bus.out_data_en), 64'(0));
        drive(0, 1'b1, 'hA1, 'h15, 1'b0); tick(1);
        chk("t1 lat edgeT1", 64'(bus.out_data_en), 64'(1));
        chk("t1 len0", 64'(bus.out_data_len), 64'(0));
        drive(0, 1'b1, 'hA2, 'h15, 1'b1); tick(1);
        drive(0, 1'b0, 0, 0, 1'b0); tick(4);
        for (int i = 0; i < 3; i++) expect_beat("t1 beat", 0, i, i == 2, 'hA0 + i, 'h15, ci);
        // four simultaneous two-beat messages
        do_reset();
        for (int c = 0; c < NC; c++) drive(c, 1'b1, 'hB000 + c * 16, 'h20 + c, 1'b0);
        tick(1);
        for (int c = 0; c < NC; c++) drive(c, 1'b1, 'hB001 + c * 16, 'h20 + c, 1'b1);
        tick(1);
        for (int c = 0; c < NC; c++) drive(c, 1'b0, 0, 0, 1'b0);
        tick(10);
        expect_beat("t2 beat", 0, 0, 0, 'hB000, 'h20, c0);
        for (int i = 1; i < 8; i++) begin
            expect_beat("t2 beat", i / 2, i % 2, i % 2, 'hB000 + (i / 2) * 16 + i % 2, 'h20 + i / 2, ci);
            chk("t2 back-to-back", 64'(ci - c0), 64'(i));
        end
        drive(0, 1'b1, 'hB100, 'h30, 1'b1);
        drive(1, 1'b1, 'hB110, 'h31, 1'b1);
        tick(1);
        drive(0, 1'b0, 0, 0, 1'b0);
        drive(1, 1'b0, 0, 0, 1'b0);
        tick(5);
        expect_beat("t2 rr wrap", 0, 0, 1, 'hB100, 'h30, ci);
        expect_beat("t2 rr next", 1, 0, 1, 'hB110, 'h31, ci);
        // ch1 twelve-beat stream with a ten-cycle output stall
        sent = 0;
        for (int k = 0; k < 40; k++) begin
            bus.out_ready = !(k >= 4 && k < 14);
            if (sent < 12) drive(1, 1'b1, 'hC00 + sent, 'h100 + sent, sent == 11);
            else drive(1, 1'b0, 0, 0, 1'b0);
            acc = bus.in_valid[1] && bus.in_ready[1];
            tick(1);
            if (acc) sent++;
            if (k == 2) chk("t3 in_ready open", 64'(bus.in_ready[1]), 64'(1));
            if (k == 8 || k == 13) begin
                chk("t3 hold data", 64'(bus.out_data[15:0]), 64'hC02);
                chk("t3 hold len", 64'(bus.out_data_len), 64'(2));
                chk("t3 hold en", 64'(bus.out_data_en), 64'(1));
                chk("t3 hold id", 64'(bus.out_id), 64'h102);
            end
            if (k == 12 || k == 13) chk("t3 in_ready full", 64'(bus.in_ready[1]), 64'(0));
            if (k == 14) chk("t3 in_ready reopen", 64'(bus.in_ready[1]), 64'(1));
        end
        for (int i = 0; i < 12; i++) expect_beat("t3 beat", 1, i, i == 11, 'hC00 + i, 'h100 + i, ci);
        // ch2 overlong message
        chk("t4 err before", 64'(bus.err_overlen), 64'(0));
        for (int i = 0; i < 18; i++) push(2, 'hD00 + i, 'h200 + i, 1'b0);
        push(2, 'hD12, 'h212, 1'b1);
        tick(5);
        for (int i = 0; i < 16; i++) expect_beat("t4 beat", 2, i, i == 15, 'hD00 + i, 'h200 + i, ci);
        expect_beat("t4 beat17", 2, 0, 0, 'hD10, 'h210, ci);
        expect_beat("t4 beat18", 2, 1, 0, 'hD11, 'h211, ci);
        expect_beat("t4 beat19", 2, 2, 1, 'hD12, 'h212, ci);
        chk("t4 err set", 64'(bus.err_overlen), 64'(1));
        // reset in the middle of a ch3 burst
        push(3, 'hE00, 'h300, 1'b0);
        push(3, 'hE01, 'h300, 1'b0);
        chk("t4 err sticky", 64'(bus.err_overlen), 64'(1));
        drive(3, 1'b1, 'hE02, 'h300, 1'b0);
        tick(1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5 rst en", 64'(bus.out_data_en), 64'(0));
        chk("t5 rst data", 64'(bus.out_data[15:0]), 64'(0));
        chk("t5 rst len", 64'(bus.out_data_len), 64'(0));
        chk("t5 rst ch", 64'(bus.out_ch), 64'(0));
        chk("t5 rst in_ready", 64'(bus.in_ready), 64'(0));
        chk("t5 rst err", 64'(bus.err_overlen), 64'(0));
        bus.in_valid = '0;
        tick(2);
        rst_n = 1'b1;
        #1;
        chk("t5 rel in_ready", 64'(bus.in_ready), 64'hF);
        expect_beat("t5 pre-reset beat", 3, 0, 0, 'hE00, 'h300, ci);
        tick(6);
        chk("t5 residual", 64'(q.size()), 64'(0));
        push(0, 'hF00, 'h400, 1'b0);
        push(0, 'hF01, 'h400, 1'b1);
        tick(4);
        expect_beat("t5 new len0", 0, 0, 0, 'hF00, 'h400, ci);
        expect_beat("t5 new len1", 0, 1, 1, 'hF01, 'h400, ci);
        // ch1 input stall mid-burst while ch0 holds a complete message
        drive(1, 1'b1, 'h1100, 'h500, 1'b0);
        drive(0, 1'b1, 'h1000, 'h501, 1'b0);
        tick(1);
        drive(1, 1'b1, 'h1101, 'h500, 1'b0);
        drive(0, 1'b1, 'h1001, 'h501, 1'b1);
        tick(1);
        drive(1, 1'b0, 0, 0, 1'b0);
        drive(0, 1'b0, 0, 0, 1'b0);
        tick(1);
        chk("t6 ch1 beat1 ch", 64'(bus.out_ch), 64'(1));
        tick(1);
        chk("t6 bubble1", 64'(bus.out_data_en), 64'(0));
        tick(1);
        chk("t6 bubble2", 64'(bus.out_data_en), 64'(0));
        drive(1, 1'b1, 'h1102, 'h500, 1'b1);
        tick(1);
        chk("t6 bubble3", 64'(bus.out_data_en), 64'(0));
        drive(1, 1'b0, 0, 0, 1'b0);
        tick(6);
        expect_beat("t6 ch1 b0", 1, 0, 0, 'h1100, 'h500, c0);
        expect_beat("t6 ch1 b1", 1, 1, 0, 'h1101, 'h500, ci);
        chk("t6 gap b1", 64'(ci - c0), 64'(1));
        expect_beat("t6 ch1 b2", 1, 2, 1, 'h1102, 'h500, ci);
        chk("t6 gap b2", 64'(ci - c0), 64'(5));
        expect_beat("t6 ch0 b0", 0, 0, 0, 'h1000, 'h501, ci);
        chk("t6 gap ch0", 64'(ci - c0), 64'(6));
        expect_beat("t6 ch0 b1", 0, 1, 1, 'h1001, 'h501, ci);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/gfifo_mchan_stream.md
Name: gfifo_mchan_stream

Overview:
- Multi-channel successor to the single-stream gfifo data/id/len transport: NUM_CH independent producer channels, each with its own DEPTH-entry beat buffer.
- Buffered beats are merged onto one output stream carrying data, transaction id, beat index and data-enable.
- A round-robin arbiter grants whole messages, so beats from different channels never interleave.
- Sits in the DUT-side emulation transport, between per-channel request generators and the gfifo output binding.

Parameters:
NUM_CH, 4, number of input channels (2..16)
DATA_W, 512, beat data width
ID_W, 22, transaction id width
LEN_W, 4, beat-index width; max message length MAX_BEATS = 2**LEN_W
DEPTH, 8, per-channel buffer depth in beats (power of 2, >= 2)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  NUM_CH  per-channel beat valid
in_ready  output  NUM_CH  per-channel space available
in_data  input  NUM_CH*DATA_W  channel c data at [c*DATA_W +: DATA_W]
in_id  input  NUM_CH*ID_W  channel c id at [c*ID_W +: ID_W]
in_last  input  NUM_CH  final beat of message
out_data  output  DATA_W  output beat data
out_id  output  ID_W  id of output beat
out_data_en  output  1  output beat valid
out_data_len  output  LEN_W  0-based beat index within message
out_last  output  1  final beat of message
out_ch  output  $clog2(NUM_CH)  source channel
out_ready  input  1  downstream accept
err_overlen  output  1  sticky: a message exceeded MAX_BEATS

Behaviour:
- Reset (rst_n low, asynchronous):
  - all outputs 0; in_ready forced 0 while rst_n low.
  - buffers emptied; state IDLE; RR pointer 0; beat counter 0; err_overlen 0.
  - Partial messages are discarded, including a message reset mid-burst.
- Input side:
  - in_ready[c] = !full[c]; a beat is written on the rising edge where in_valid[c] && in_ready[c].
  - No bypass: a full buffer does not accept a beat even when it pops that same cycle.
  - in_ready rises the cycle after the pop.
- Output register:
  - Slot is free when !out_data_en || out_ready.
  - While out_data_en && !out_ready, every out_* signal holds stable.
- FSM IDLE:
  - If slot free and any buffer is non-empty, select the first non-empty channel searching from RR pointer upward, with wrap.
  - Pop its head into the output register: out_data_len = 0, out_ch = c.
  - RR pointer <= (c+1) mod NUM_CH.
  - If the head has in_last, stay IDLE; else go to BURST with grant = c and beat count 1.
  - If slot free and all buffers are empty, clear out_data_en.
- FSM BURST:
  - Only the granted channel may pop; other channels wait.
  - If slot free and grant buffer non-empty: pop, out_data_len = count, count++.
  - If the popped beat has last, go to IDLE.
  - If slot free and grant buffer empty: out_data_en <= 0 (bubble); stay BURST.
- Overlength:
  - If count == MAX_BEATS-1 and the beat lacks last, force out_last = 1 and set err_overlen.
  - Return to IDLE; following beats of that channel form a new message.
- Latency: a beat accepted at edge T into an empty block with out_ready = 1 appears with out_data_en = 1 after edge T+1.
- Throughput: 1 beat/cycle sustained within a message, and across message boundaries with no idle cycle.
- out_last = in_last of the popped beat, or forced on overlength.
- out_id is the per-beat id and is not checked for consistency within a message.

Test Plan:
- Ch0 sends 3 beats (id 0x15, data 0xA0/0xA1/0xA2, last on 3rd), out_ready = 1 -> out_data_en first high one cycle after first accept; out_data_len 0,1,2; out_last on 3rd only; out_ch = 0.
- All 4 channels present 2-beat messages in the same cycle -> output order ch0,ch0,ch1,ch1,ch2,ch2,ch3,ch3 over 8 consecutive cycles; no interleave; next arbitration starts at ch0.
- Ch1 streams 12 beats continuously; out_ready low for 10 cycles mid-burst -> outputs held stable; ch1 buffer reaches 8; in_ready[1] = 0; all 12 beats delivered in order, none lost.
- Ch2 sends 18 beats with no last -> beat 16 carries out_data_len 15 and out_last = 1; err_overlen = 1 and stays 1; beats 17-18 emitted with len 0,1.
- Reset asserted mid-burst on ch3 (beat 2 of 5) -> all outputs 0 asynchronously; after release, in_ready = 4'hF; no residual beats emitted; a new ch0 message starts at len 0.
- Ch1 mid-burst stalls its input for 3 cycles while ch0 has a full message buffered -> 3 bubble cycles (out_data_en = 0); ch0 not granted until ch1 last is emitted.
